hidden_layer_forward: RTL

Forward-pass engine for the hidden layer of the drowsiness-detector network. On a `start` pulse it snapshots the input vector, the input-to-hidden weights and the biases. A single shared multiplier then computes each hidden neuron's weighted sum, one product per cycle. Each sum goes through a piecewise-linear sigmoid, and the block publishes `out0_cal[0:N_HID-1]`: the activations that the backward pass consumes as its per-neuron outputs. All values use the team's fixed-point format, in which 1000 represents 1.0.

---
 rtl/hidden_layer_forward_pkg.sv | 20 ++
 rtl/sigmoid_pwl.sv | 45 ++++
 rtl/hidden_layer_forward.sv | 113 +++++++++++
 3 files changed

// File: rtl/hidden_layer_forward_pkg.sv
// Shared constants and state encoding for the hidden-layer forward engine.
// Fixed-point convention: SCALE (1000) represents 1.0.
package hidden_fwd_pkg;

  localparam int DATA_W  = 10;
  localparam int ACC_W   = 24;
  localparam int SCALE   = 1000;
  localparam int SIG_MID = 500;
  localparam int SIG_MAX = 1000;
  localparam int SAT_MIN = -512;
  localparam int SAT_MAX = 511;

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    ACT,
    DONE
  } fwd_state_t;

endpackage

// File: rtl/sigmoid_pwl.sv
// Piecewise-linear sigmoid: rescale the accumulator, add the bias, saturate,
// and map onto 500 + z/4 clamped to [0, 1000]. Purely combinational.
module sigmoid_pwl
  import hidden_fwd_pkg::*;
(
  input  logic signed [ACC_W-1:0]  acc,
  input  logic signed [DATA_W-1:0] bias,
  output logic        [DATA_W-1:0] y
);

  localparam int YW = DATA_W + 2;

  localparam logic signed [ACC_W-1:0]  SCALE_S = ACC_W'(SCALE);
  localparam logic signed [ACC_W-1:0]  SAT_LO  = ACC_W'(SAT_MIN);
  localparam logic signed [ACC_W-1:0]  SAT_HI  = ACC_W'(SAT_MAX);
  localparam logic signed [YW-1:0]     Y_MID   = YW'(SIG_MID);
  localparam logic signed [YW-1:0]     Y_MAX   = YW'(SIG_MAX);

  logic signed [ACC_W-1:0]  q;
  logic signed [ACC_W-1:0]  z;
  logic signed [DATA_W-1:0] zs;
  logic signed [DATA_W-1:0] sh;
  logic signed [YW-1:0]     ys;

  always_comb begin
    // Signed division truncates toward zero; the later shift floors.
    q  = acc / SCALE_S;
    z  = q + signed'({{(ACC_W-DATA_W){bias[DATA_W-1]}}, bias});
    if (z > SAT_HI)
      zs = SAT_HI[DATA_W-1:0];
    else if (z < SAT_LO)
      zs = SAT_LO[DATA_W-1:0];
    else
      zs = z[DATA_W-1:0];
    sh = zs >>> 2;
    ys = Y_MID + signed'({{2{sh[DATA_W-1]}}, sh});
    if (ys < 0)
      y = '0;
    else if (ys > Y_MAX)
      y = Y_MAX[DATA_W-1:0];
    else
      y = ys[DATA_W-1:0];
  end

endmodule

// File: rtl/hidden_layer_forward.sv
// Hidden-layer forward pass: one shared multiplier walks every (neuron, input)
// pair, then each sum passes through sigmoid_pwl; results publish atomically.
module hidden_layer_forward
  import hidden_fwd_pkg::*;
#(
  parameter int N_IN  = 4,
  parameter int N_HID = 5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic signed [DATA_W-1:0] in_vec    [N_IN],
  input  logic signed [DATA_W-1:0] weight_ih [N_HID][N_IN],
  input  logic signed [DATA_W-1:0] bias      [N_HID],
  output logic                     busy,
  output logic                     done,
  output logic                     out_valid,
  output logic        [DATA_W-1:0] out0_cal  [N_HID]
);

  localparam int IW = (N_IN  > 1) ? $clog2(N_IN)  : 1;
  localparam int JW = (N_HID > 1) ? $clog2(N_HID) : 1;
  localparam logic [IW-1:0] I_LAST = IW'(N_IN - 1);
  localparam logic [JW-1:0] J_LAST = JW'(N_HID - 1);

  fwd_state_t state_q, state_d;

  logic        [IW-1:0]     i_q;
  logic        [JW-1:0]     j_q;
  logic signed [ACC_W-1:0]  acc_q;
  logic signed [DATA_W-1:0] in_snap   [N_IN];
  logic signed [DATA_W-1:0] w_snap    [N_HID][N_IN];
  logic signed [DATA_W-1:0] bias_snap [N_HID];
  logic        [DATA_W-1:0] res_q     [N_HID];

  logic signed [2*DATA_W-1:0] prod;
  logic        [DATA_W-1:0]   act_y;

  assign prod = in_snap[i_q] * w_snap[j_q][i_q];

  sigmoid_pwl u_sigmoid (
    .acc  (acc_q),
    .bias (bias_snap[j_q]),
    .y    (act_y)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = MAC;
      MAC:     if (i_q == I_LAST) state_d = ACT;
      ACT:     state_d = (j_q == J_LAST) ? DONE : MAC;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i_q       <= '0;
      j_q       <= '0;
      acc_q     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      out_valid <= 1'b0;
      for (int unsigned n = 0; n < N_IN; n++) in_snap[n] <= '0;
      for (int unsigned h = 0; h < N_HID; h++) begin
        bias_snap[h] <= '0;
        res_q[h]     <= '0;
        out0_cal[h]  <= '0;
        for (int unsigned n = 0; n < N_IN; n++) w_snap[h][n] <= '0;
      end
    end else begin
      // busy stays high through the done cycle (state already IDLE there).
      busy <= (state_q == IDLE) ? start : 1'b1;
      done <= (state_q == DONE);
      case (state_q)
        IDLE: begin
          if (start) begin
            in_snap   <= in_vec;
            w_snap    <= weight_ih;
            bias_snap <= bias;
            out_valid <= 1'b0;
            i_q       <= '0;
            j_q       <= '0;
            acc_q     <= '0;
          end
        end
        MAC: begin
          acc_q <= acc_q + ACC_W'(prod);
          if (i_q != I_LAST) i_q <= i_q + 1'b1;
        end
        ACT: begin
          res_q[j_q] <= act_y;
          acc_q      <= '0;
          i_q        <= '0;
          if (j_q != J_LAST) j_q <= j_q + 1'b1;
        end
        DONE: begin
          out0_cal  <= res_q;
          out_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
